uart_dbg_bridge: RTL and testbench

Debug/monitor bridge that consumes the received-byte stream of the system UART (`rxdata`/`rxnew`) and turns framed byte commands into single-word transactions on the CPU-side memory bus (`a`/`d`/`we`/`rd`/`spo`/`ready`), the same interface the memory mapper accepts.
- It sits downstream of the UART receiver and in parallel with the UART reset detector and serial boot.
- Its bus master port is muxed ahead of the memory mapper.
- Responses leave as a byte stream for a transmit path.

---
 rtl/uart_dbg_pkg.sv | 30 +++
 rtl/uart_dbg_bridge_if.sv | 21 ++
 rtl/dbg_resp_ser.sv | 57 +++++
 rtl/uart_dbg_bridge.sv | 188 ++++++++++++++++++
 tb/tb_uart_dbg_bridge.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_dbg_pkg.sv
// Shared constants and types for the UART debug bridge: frame opcodes,
// response bytes and the frame FSM state encoding.
package uart_dbg_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;  // 'R'

    localparam logic [7:0] RSP_OK   = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_UNK  = 8'h3F;  // '?'
    localparam logic [7:0] RSP_TMO  = 8'h54;  // 'T'
    localparam logic [7:0] RSP_BERR = 8'h45;  // 'E'

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ);
    endfunction

    // Single-byte responses sit in the low byte of the serializer word.
    function automatic logic [31:0] short_resp(input logic [7:0] b);
        return {24'h0, b};
    endfunction

endpackage

// File: rtl/uart_dbg_bridge_if.sv
// CPU-side single-word memory bus driven by the debug bridge.
// Handshake: we/rd is held high with a/d stable until the cycle ready=1;
// spo is valid only in that cycle, and we/rd are low the cycle after it.
interface uart_dbg_bridge_if;
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic        rd;
    logic [31:0] spo;
    logic        ready;

    modport master (
        output a, d, we, rd,
        input  spo, ready
    );

    modport slave (
        input  a, d, we, rd,
        output spo, ready
    );
endinterface

// File: rtl/dbg_resp_ser.sv
// Response serializer: loaded with a word and a length of 1 or 4 bytes,
// it presents them MSB first with a one-cycle gap after every accepted byte.
module dbg_resp_ser (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic        load_len4,
    output logic [7:0]  resp_data,
    output logic        resp_valid,
    input  logic        resp_ack,
    output logic        done
);

    logic [31:0] word_q;
    logic [1:0]  idx_q;
    logic        valid_q;
    logic        pend_q;
    logic [7:0]  data_q;

    assign resp_data  = data_q;
    assign resp_valid = valid_q;
    assign done       = valid_q && resp_ack && (idx_q == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            word_q  <= load_word;
            valid_q <= 1'b1;
            pend_q  <= 1'b0;
            if (load_len4) begin
                idx_q  <= 2'd3;
                data_q <= load_word[31:24];
            end else begin
                idx_q  <= 2'd0;
                data_q <= load_word[7:0];
            end
        end else if (valid_q && resp_ack) begin
            valid_q <= 1'b0;
            if (idx_q != 2'd0) begin
                idx_q  <= idx_q - 2'd1;
                pend_q <= 1'b1;
            end
        end else if (pend_q) begin
            // idx_q already points at the next byte to present
            valid_q <= 1'b1;
            pend_q  <= 1'b0;
            data_q  <= word_q[{idx_q, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/uart_dbg_bridge.sv
// UART debug bridge: parses 'W'/'R' byte frames from the UART receiver into
// single-word bus transactions and streams back a byte response.
module uart_dbg_bridge
    import uart_dbg_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 1000000,
    parameter int BUS_TIMEOUT  = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            uart_data,
    input  logic                  uart_ready,
    uart_dbg_bridge_if.master     bus,
    output logic [7:0]            resp_data,
    output logic                  resp_valid,
    input  logic                  resp_ack,
    output logic                  busy,
    output logic                  overrun,
    output state_t                state_dbg
);

    localparam int BT_W  = $clog2(BYTE_TIMEOUT + 1);
    localparam int BUS_W = $clog2(BUS_TIMEOUT + 1);

    state_t             state_q, state_d;
    logic               is_write_q;
    logic [31:0]        addr_q;
    logic [31:0]        data_q;
    logic [1:0]         cnt_q;
    logic [BT_W-1:0]    byte_tmr_q;
    logic [BUS_W-1:0]   bus_tmr_q;
    logic               we_q;
    logic               rd_q;
    logic               overrun_q;

    logic               byte_hit;
    logic               bus_hit;
    logic               ser_load;
    logic [31:0]        ser_word;
    logic               ser_len4;
    logic               ser_done;

    assign byte_hit  = (byte_tmr_q == BT_W'(BYTE_TIMEOUT));
    assign bus_hit   = (bus_tmr_q == BUS_W'(BUS_TIMEOUT));

    assign bus.a     = addr_q;
    assign bus.d     = data_q;
    assign bus.we    = we_q;
    assign bus.rd    = rd_q;
    assign busy      = (state_q != ST_IDLE);
    assign overrun   = overrun_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d  = state_q;
        ser_load = 1'b0;
        ser_word = '0;
        ser_len4 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (uart_ready) begin
                    if (is_opcode(uart_data)) begin
                        state_d = ST_ADDR;
                    end else begin
                        ser_load = 1'b1;
                        ser_word = short_resp(RSP_UNK);
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                // A byte arriving on the timeout cycle still counts.
                if (uart_ready) begin
                    if (cnt_q == 2'd3) begin
                        state_d = is_write_q ? ST_DATA : ST_BUS;
                    end
                end else if (byte_hit) begin
                    ser_load = 1'b1;
                    ser_word = short_resp(RSP_TMO);
                    state_d  = ST_RESP;
                end
            end
            ST_DATA: begin
                if (uart_ready) begin
                    if (cnt_q == 2'd3) begin
                        state_d = ST_BUS;
                    end
                end else if (byte_hit) begin
                    ser_load = 1'b1;
                    ser_word = short_resp(RSP_TMO);
                    state_d  = ST_RESP;
                end
            end
            ST_BUS: begin
                if (bus.ready) begin
                    ser_load = 1'b1;
                    if (is_write_q) begin
                        ser_word = short_resp(RSP_OK);
                    end else begin
                        ser_word = bus.spo;
                        ser_len4 = 1'b1;
                    end
                    state_d = ST_RESP;
                end else if (bus_hit) begin
                    ser_load = 1'b1;
                    ser_word = short_resp(RSP_BERR);
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (ser_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            byte_tmr_q <= '0;
            bus_tmr_q  <= '0;
            we_q       <= 1'b0;
            rd_q       <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (uart_ready && is_opcode(uart_data)) begin
                        is_write_q <= (uart_data == OP_WRITE);
                        cnt_q      <= '0;
                        byte_tmr_q <= '0;
                    end
                end
                ST_ADDR, ST_DATA: begin
                    if (uart_ready) begin
                        byte_tmr_q <= '0;
                        cnt_q      <= cnt_q + 2'd1;
                        if (state_q == ST_ADDR) begin
                            addr_q <= {addr_q[23:0], uart_data};
                        end else begin
                            data_q <= {data_q[23:0], uart_data};
                        end
                    end else if (!byte_hit) begin
                        byte_tmr_q <= byte_tmr_q + BT_W'(1);
                    end
                end
                ST_BUS: begin
                    if (bus.ready || bus_hit) begin
                        we_q <= 1'b0;
                        rd_q <= 1'b0;
                    end else begin
                        bus_tmr_q <= bus_tmr_q + BUS_W'(1);
                    end
                end
                default: ;
            endcase
            // Request goes out in the cycle right after the frame's last byte.
            if (state_d == ST_BUS && state_q != ST_BUS) begin
                we_q      <= is_write_q;
                rd_q      <= !is_write_q;
                bus_tmr_q <= '0;
            end
            if (uart_ready && (state_q == ST_BUS || state_q == ST_RESP)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    dbg_resp_ser u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ser_load),
        .load_word  (ser_word),
        .load_len4  (ser_len4),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .resp_ack   (resp_ack),
        .done       (ser_done)
    );

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Bench for uart_dbg_bridge: directed frames plus randomized traffic against
// a frame-level model with a memory-backed bus slave and a stalling consumer.
module tb_uart_dbg_bridge;
  import uart_dbg_pkg::*;

  localparam int BYTE_TO = 100;
  localparam int BUS_TO  = 50;

  typedef struct packed {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
  } bus_op_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] uart_data;
  logic       uart_ready;
  logic [7:0] resp_data;
  logic       resp_valid;
  logic       resp_ack;
  logic       busy;
  logic       overrun;
  state_t     state_dbg;

  uart_dbg_bridge_if bus_if ();

  uart_dbg_bridge #(
    .BYTE_TIMEOUT (BYTE_TO),
    .BUS_TIMEOUT  (BUS_TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_data  (uart_data),
    .uart_ready (uart_ready),
    .bus        (bus_if),
    .resp_data  (resp_data),
    .resp_valid (resp_valid),
    .resp_ack   (resp_ack),
    .busy       (busy),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  // scoreboard and reference model state
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  bus_op_t     bus_exp_q[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];
  int          lat_cfg = 1;
  bit          never_ready = 1'b0;
  bit          stall_en = 1'b0;

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    chk32(tag, 32'(got), 32'(exp));
  endtask

  task automatic chk_range(input string tag, input int got, input int lo, input int hi);
    n_vec++;
    assert (got >= lo && got <= hi) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  function automatic logic [31:0] mem_default(input logic [31:0] addr);
    return (addr * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] addr);
    return model_mem.exists(addr) ? model_mem[addr] : mem_default(addr);
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] addr);
    return slave_mem.exists(addr) ? slave_mem[addr] : mem_default(addr);
  endfunction

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_data  = b;
    uart_ready = 1'b1;
    @(negedge clk);
    uart_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input bit with_data);
    send_byte(op);
    for (int i = 3; i >= 0; i--) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(addr[i*8 +: 8]);
    end
    if (with_data) begin
      for (int i = 3; i >= 0; i--) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_byte(data[i*8 +: 8]);
      end
    end
    chk1("we_after_last_byte", bus_if.we, with_data);
    chk1("rd_after_last_byte", bus_if.rd, !with_data);
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [31:0] data);
    bus_exp_q.push_back('{1'b1, addr, data});
    exp_q.push_back(RSP_OK);
    model_mem[addr] = data;
    send_frame(OP_WRITE, addr, data, 1'b1);
  endtask

  task automatic run_read(input logic [31:0] addr, input bit timeout);
    logic [31:0] v;
    bus_exp_q.push_back('{1'b0, addr, 32'h0});
    if (timeout) begin
      exp_q.push_back(RSP_BERR);
    end else begin
      v = model_rd(addr);
      for (int i = 3; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
    end
    send_frame(OP_READ, addr, 32'h0, 1'b0);
  endtask

  task automatic run_unknown(input logic [7:0] b);
    exp_q.push_back(RSP_UNK);
    send_byte(b);
    chk1("unk_resp_valid_next", resp_valid, 1'b1);
    chk1("unk_no_we", bus_if.we, 1'b0);
    chk1("unk_no_rd", bus_if.rd, 1'b0);
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus_exp_q.size() == 0 && !busy && !resp_valid) done = 1'b1;
    end
    chk1({"idle_", tag}, done, 1'b1);
  endtask

  // bus slave: memory backed, ready after lat_cfg cycles of request
  logic        active = 1'b0;
  int          hi = 0;
  int          cur_lat = 1;
  logic        cur_wr;
  logic [31:0] cur_a;
  logic [31:0] cur_d;
  bus_op_t     op;

  initial begin
    bus_if.ready = 1'b0;
    bus_if.spo   = '0;
    forever begin
      @(negedge clk);
      bus_if.ready = 1'b0;
      bus_if.spo   = $urandom();
      if (!rst_n) begin
        active = 1'b0;
      end else if (bus_if.we || bus_if.rd) begin
        if (!active) begin
          active  = 1'b1;
          hi      = 0;
          cur_wr  = bus_if.we;
          cur_a   = bus_if.a;
          cur_d   = bus_if.d;
          cur_lat = lat_cfg;
          chk1("bus_req_expected", bus_exp_q.size() != 0, 1'b1);
          if (bus_exp_q.size() != 0) begin
            op = bus_exp_q.pop_front();
            chk1("bus_dir", bus_if.we, op.wr);
            chk32("bus_addr", bus_if.a, op.a);
            if (op.wr) chk32("bus_wdata", bus_if.d, op.d);
          end
        end else begin
          chk32("bus_a_stable", bus_if.a, cur_a);
          chk32("bus_d_stable", bus_if.d, cur_d);
        end
        hi++;
        if (!never_ready && hi == cur_lat) begin
          bus_if.ready = 1'b1;
          if (cur_wr) slave_mem[cur_a] = cur_d;
          else bus_if.spo = slave_rd(cur_a);
        end
      end else if (active) begin
        active = 1'b0;
        if (never_ready) chk_range("bus_timeout_len", hi, BUS_TO, BUS_TO + 1);
        else chk32("bus_req_len", 32'(hi), 32'(cur_lat));
      end
    end
  end

  // response consumer with random stalls
  logic       held = 1'b0;
  logic [7:0] held_data;
  logic       after_ack = 1'b0;

  initial begin
    resp_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        resp_ack  = 1'b0;
        held      = 1'b0;
        after_ack = 1'b0;
      end else begin
        if (after_ack) chk1("resp_gap_after_ack", resp_valid, 1'b0);
        if (held) begin
          chk1("resp_hold_valid", resp_valid, 1'b1);
          chk32("resp_hold_data", 32'(resp_data), 32'(held_data));
        end
        after_ack = 1'b0;
        held      = 1'b0;
        resp_ack  = 1'b0;
        if (resp_valid) begin
          if (!stall_en || $urandom_range(0, 3) == 0) begin
            resp_ack  = 1'b1;
            after_ack = 1'b1;
            chk1("resp_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) chk32("resp_byte", 32'(resp_data), 32'(exp_q.pop_front()));
          end else begin
            held      = 1'b1;
            held_data = resp_data;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // directed sequence
  initial begin
    logic [31:0] ra;
    logic [7:0]  ub;
    int          first;
    int          k;
    bit          got;

    rst_n      = 1'b0;
    uart_data  = '0;
    uart_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk32("rst_a", bus_if.a, 32'h0);
    chk32("rst_d", bus_if.d, 32'h0);
    chk1("rst_we", bus_if.we, 1'b0);
    chk1("rst_rd", bus_if.rd, 1'b0);
    chk32("rst_resp_data", 32'(resp_data), 32'h0);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_overrun", overrun, 1'b0);
    chk32("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    chk1("post_rst_busy", busy, 1'b0);

    // write with ready on the third request cycle
    lat_cfg  = 3;
    stall_en = 1'b0;
    run_write(32'h8000_0010, 32'hDEAD_BEEF);
    wait_idle("write");

    // read with stalled consumer
    model_mem[32'h400] = 32'h1234_5678;
    slave_mem[32'h400] = 32'h1234_5678;
    lat_cfg  = 2;
    stall_en = 1'b1;
    run_read(32'h0000_0400, 1'b0);
    wait_idle("read");

    run_unknown(8'h41);
    wait_idle("unknown");
    chk1("unk_busy_low", busy, 1'b0);

    // byte timeout mid-address
    exp_q.push_back(RSP_TMO);
    send_byte(OP_WRITE);
    send_byte(8'h00);
    send_byte(8'h00);
    first = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        first = c;
        break;
      end
    end
    chk_range("byte_timeout_cycles", first, BYTE_TO, BYTE_TO + 2);
    wait_idle("byte_timeout");
    run_read(32'h2000_0008, 1'b0);
    wait_idle("read_after_timeout");

    // bus timeout
    never_ready = 1'b1;
    run_read(32'hCAFE_0000, 1'b1);
    wait_idle("bus_timeout");
    never_ready = 1'b0;

    // byte dropped while responding
    chk1("overrun_clear", overrun, 1'b0);
    stall_en = 1'b1;
    lat_cfg  = 1;
    run_read(32'h0000_0400, 1'b0);
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk1("resp_seen", got, 1'b1);
    chk32("state_in_resp", 32'(state_dbg), 32'(ST_RESP));
    send_byte(8'h99);
    chk1("overrun_set", overrun, 1'b1);
    wait_idle("overrun");

    // randomized traffic
    for (int i = 0; i < 24; i++) begin
      lat_cfg  = $urandom_range(1, 5);
      stall_en = 1'($urandom_range(0, 1));
      ra = 32'h1000_0000 | (32'($urandom_range(0, 7)) << 2);
      k  = $urandom_range(0, 9);
      if (k < 4) begin
        run_write(ra, $urandom());
      end else if (k < 8) begin
        run_read(ra, 1'b0);
      end else begin
        do ub = 8'($urandom_range(0, 255)); while (ub == OP_WRITE || ub == OP_READ);
        run_unknown(ub);
      end
      wait_idle("random");
    end

    // asynchronous reset in the middle of a frame
    send_byte(OP_READ);
    send_byte(8'h00);
    send_byte(8'h11);
    chk1("pre_rst_busy", busy, 1'b1);
    chk1("pre_rst_overrun", overrun, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk32("arst_a", bus_if.a, 32'h0);
    chk32("arst_d", bus_if.d, 32'h0);
    chk1("arst_we", bus_if.we, 1'b0);
    chk1("arst_rd", bus_if.rd, 1'b0);
    chk32("arst_resp_data", 32'(resp_data), 32'h0);
    chk1("arst_resp_valid", resp_valid, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_overrun", overrun, 1'b0);
    chk32("arst_state", 32'(state_dbg), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk1("post_arst_no_resp", resp_valid, 1'b0);
    stall_en = 1'b1;
    lat_cfg  = 2;
    run_write(32'h3000_0004, 32'h0BAD_CAFE);
    wait_idle("write_after_reset");
    run_read(32'h3000_0004, 1'b0);
    wait_idle("read_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
